intersection_phase_scheduler: RTL and testbench
===============================================

// Module: intersection_phase_scheduler
// PURPOSE
//  Round-robin phase scheduler that shares one intersection between four phases:
//  MAIN (the rest phase), SIDE, LEFT and WALK.
//  Latches requests, enforces min/max green, yellow and all-red clearance, and drives one-hot lamp grants.
//  Inserts MAIN between any two non-MAIN services.
//  Sits above the lamp drivers and replaces ad-hoc per-light sequencing; all timing counts in 1 s ticks.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per tick (sim: 4); must be >= 2
//  MIN_GREEN  6           ticks; minimum green on any vehicle phase
//  MAX_GREEN  12          ticks; cap on SIDE/LEFT green while extension held; must be >= MIN_GREEN
//  YELLOW_T   2           ticks; yellow after a vehicle phase
//  ALLRED_T   1           ticks; all-red clearance after every phase
//  WALK_T     3           ticks; walk lamp duration
//  All durations are 1..63; the timer is 6 bits.
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  req_in     in   3  level requests [0]=SIDE [1]=LEFT [2]=WALK (sensors/button, pre-synchronised)
//  grant      out  4  one-hot green: [0]=MAIN [1]=SIDE [2]=LEFT [3]=WALK lamp; 0 in YELLOW/ALLRED
//  yellow     out  3  one-hot yellow: [0]=MAIN [1]=SIDE [2]=LEFT
//  all_red    out  1  high in the ALLRED state
//  cur_phase  out  2  phase being served or cleared: 0 MAIN, 1 SIDE, 2 LEFT, 3 WALK
//  req_pend   out  3  latched pending requests (status)
// BEHAVIOUR
//  Reset values:
//   - state=GREEN, cur_phase=0, grant=4'b0001, yellow=0, all_red=0, req_pend=0, timer=0, prescaler=0, rr_ptr=SIDE.
//   - rst is sampled on every clk edge and overrides tick. A reset mid-operation returns all of the above on the next edge and drops pending requests.
//  Tick:
//   - The prescaler counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for one clk when prescaler==TICK_DIV-1.
//   - The FSM and timer change only on tick cycles.
//  Timer:
//   - Cleared to 0 on state entry; increments on each tick; saturates at 63.
//   - A state of duration D exits on the tick where timer==D-1, so it lasts exactly D ticks.
//  Request latch:
//   - req_pend[i] sets on any clk cycle with req_in[i]=1.
//   - It clears on the cycle that phase i enters GREEN; a coincident req_in[i] that cycle is absorbed.
//   - req_in[i] for the phase currently in GREEN does not latch. For SIDE/LEFT it acts as an extension; for WALK it is ignored.
//  FSM GREEN, cur_phase=MAIN:
//   - Leaves at timer>=MIN_GREEN-1 on a tick with req_pend!=0.
//   - Otherwise rests indefinitely.
//   - Next state: YELLOW.
//  FSM GREEN, cur_phase=SIDE/LEFT:
//   - At timer>=MIN_GREEN-1, leaves if req_in for the own phase is low.
//   - Forced exit at timer==MAX_GREEN-1.
//   - Next state: YELLOW.
//  FSM GREEN, cur_phase=WALK:
//   - grant[3] high; exits at timer==WALK_T-1.
//   - Next state: ALLRED (WALK has no yellow).
//  FSM YELLOW:
//   - Lasts YELLOW_T ticks, then goes to ALLRED.
//  FSM ALLRED, next-phase selection at exit (after ALLRED_T ticks):
//   - If cur_phase!=MAIN, next=MAIN.
//   - If cur_phase==MAIN, next=the first pending phase scanning rr_ptr, rr_ptr+1, ... (mod 3 over SIDE, LEFT, WALK).
//   - rr_ptr then advances to the phase after the one selected.
//   - If nothing is pending when MAIN's ALLRED ends (cannot happen by construction), next=MAIN.
//  Simultaneous events:
//   - Several requests pending are resolved by rr_ptr order only; arrival order is irrelevant.
//   - A tick in the same cycle as a request: the request is latched, and the FSM sees the pre-latch req_pend on that tick.
//  Outputs:
//   - Decoded combinationally from the state/cur_phase registers.
//   - Exactly one of grant, yellow or all_red is active in every cycle.
// STRUCTURE
//  Shared package traffic_pkg:
//   - phase encodings PH_MAIN/PH_SIDE/PH_LEFT/PH_WALK
//   - state enum ST_GREEN/ST_YELLOW/ST_ALLRED
//   - TIMER_W=6
//  One sub-module, tick_gen:
//   - parameter TICK_DIV; ports clk, rst, tick.
//   - Reusable by the other light blocks.
//  The rest is one FSM, the request latch and the round-robin selector in this file.
// TESTING  (TICK_DIV=4, defaults otherwise)
//  1. Reset, no requests, 100 ticks -> grant=0001 throughout; yellow and all_red never set.
//  2. Pulse req_in[0] one clk at tick 2:
//     - req_pend=001.
//     - MAIN green ends after tick 6; yellow[0] for 2 ticks; all_red for 1 tick.
//     - grant=0010 for 6 ticks, req_pend=000, then back to MAIN.
//  3. Hold req_in[1] continuously while LEFT is green -> LEFT green lasts exactly 12 ticks (MAX_GREEN cap), then yellow[2].
//  4. Latch req_in=111 together during MAIN green:
//     - Service order SIDE, MAIN, LEFT, MAIN, WALK, MAIN.
//     - WALK runs grant=1000 for 3 ticks, then all_red with no yellow.
//  5. Assert rst for one clk during SIDE yellow with LEFT pending -> next cycle grant=0001, req_pend=000, timer=0.
//  6. Every cycle, assert $onehot({grant,yellow,all_red}).
//     Also check that req_in for the phase currently green never sets req_pend.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection light controllers: phases, FSM states
// and the round-robin successor used when picking the next phase to serve.
package traffic_pkg;

    localparam int TIMER_W = 6;
    localparam logic [TIMER_W-1:0] TIMER_SAT = '1;

    typedef enum logic [1:0] {
        PH_MAIN = 2'd0,
        PH_SIDE = 2'd1,
        PH_LEFT = 2'd2,
        PH_WALK = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    // Successor in the SIDE -> LEFT -> WALK -> SIDE rotation; MAIN never rotates.
    function automatic phase_t rr_next(input phase_t p);
        case (p)
            PH_SIDE: rr_next = PH_LEFT;
            PH_LEFT: rr_next = PH_WALK;
            default: rr_next = PH_SIDE;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clk tick every TICK_DIV clocks.
// Shared by the light controllers so all of them agree on the 1 s time base.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase scheduler for one intersection: MAIN rests, SIDE/LEFT/WALK
// are served on request with MAIN inserted between any two of them.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_GREEN  | r_phase has its green (or walk) lamp; min/max green enforced
//   ST_YELLOW | clearing a vehicle phase (never entered from WALK)
//   ST_ALLRED | all-red clearance; next phase chosen on exit
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MIN_GREEN = 6,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_in,
    output logic [3:0] grant,
    output logic [2:0] yellow,
    output logic       all_red,
    output logic [1:0] cur_phase,
    output logic [2:0] req_pend
);

    localparam logic [TIMER_W-1:0] MIN_LAST  = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_LAST  = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] AR_LAST   = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST = TIMER_W'(WALK_T - 1);

    state_t               r_state;
    phase_t               r_phase;
    phase_t               r_rr;
    logic [TIMER_W-1:0]   r_timer;
    logic [2:0]           r_pend;

    state_t               w_state_nxt;
    phase_t               w_phase_nxt;
    phase_t               w_rr_nxt;
    phase_t               w_sel;
    logic                 w_tick;
    logic                 w_own_req;
    logic [2:0]           w_green_own;
    logic [2:0]           w_pend_nxt;

    function automatic logic is_pending(input logic [2:0] pend, input phase_t p);
        case (p)
            PH_SIDE: is_pending = pend[0];
            PH_LEFT: is_pending = pend[1];
            PH_WALK: is_pending = pend[2];
            default: is_pending = 1'b0;
        endcase
    endfunction

    // First pending phase scanning from start in rotation order; MAIN if none.
    function automatic phase_t pick(input logic [2:0] pend, input phase_t start);
        phase_t c;
        logic   done;
        c    = start;
        done = 1'b0;
        pick = PH_MAIN;
        for (int k = 0; k < 3; k++) begin
            if (!done && is_pending(pend, c)) begin
                pick = c;
                done = 1'b1;
            end
            c = rr_next(c);
        end
    endfunction

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        w_green_own = 3'b000;
        if (r_state == ST_GREEN) begin
            case (r_phase)
                PH_SIDE: w_green_own = 3'b001;
                PH_LEFT: w_green_own = 3'b010;
                PH_WALK: w_green_own = 3'b100;
                default: w_green_own = 3'b000;
            endcase
        end
        w_own_req = (r_phase == PH_SIDE) ? req_in[0] : req_in[1];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_rr_nxt    = r_rr;
        w_sel       = pick(r_pend, r_rr);
        if (w_tick) begin
            case (r_state)
                ST_GREEN: begin
                    case (r_phase)
                        PH_MAIN: begin
                            if (r_timer >= MIN_LAST && r_pend != 3'b000)
                                w_state_nxt = ST_YELLOW;
                        end
                        PH_SIDE, PH_LEFT: begin
                            if (r_timer >= MAX_LAST || (r_timer >= MIN_LAST && !w_own_req))
                                w_state_nxt = ST_YELLOW;
                        end
                        default: begin
                            if (r_timer >= WALK_LAST)
                                w_state_nxt = ST_ALLRED;
                        end
                    endcase
                end
                ST_YELLOW: begin
                    if (r_timer >= YEL_LAST)
                        w_state_nxt = ST_ALLRED;
                end
                ST_ALLRED: begin
                    if (r_timer >= AR_LAST) begin
                        w_state_nxt = ST_GREEN;
                        if (r_phase != PH_MAIN) begin
                            w_phase_nxt = PH_MAIN;
                        end else if (r_pend != 3'b000) begin
                            w_phase_nxt = w_sel;
                            w_rr_nxt    = rr_next(w_sel);
                        end else begin
                            w_phase_nxt = PH_MAIN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_GREEN;
                    w_phase_nxt = PH_MAIN;
                end
            endcase
        end
    end

    // Requests for the phase already green are extensions, not new demand;
    // the bit of a phase entering green is cleared even if requested now.
    always_comb begin
        w_pend_nxt = r_pend | (req_in & ~w_green_own);
        if (r_state != ST_GREEN && w_state_nxt == ST_GREEN) begin
            case (w_phase_nxt)
                PH_SIDE: w_pend_nxt[0] = 1'b0;
                PH_LEFT: w_pend_nxt[1] = 1'b0;
                PH_WALK: w_pend_nxt[2] = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GREEN;
            r_phase <= PH_MAIN;
            r_rr    <= PH_SIDE;
            r_timer <= '0;
            r_pend  <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_rr    <= w_rr_nxt;
            r_pend  <= w_pend_nxt;
            if (w_tick) begin
                if (w_state_nxt != r_state)
                    r_timer <= '0;
                else if (r_timer != TIMER_SAT)
                    r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        grant   = 4'b0000;
        yellow  = 3'b000;
        all_red = 1'b0;
        case (r_state)
            ST_GREEN: begin
                case (r_phase)
                    PH_MAIN: grant = 4'b0001;
                    PH_SIDE: grant = 4'b0010;
                    PH_LEFT: grant = 4'b0100;
                    default: grant = 4'b1000;
                endcase
            end
            ST_YELLOW: begin
                case (r_phase)
                    PH_MAIN: yellow = 3'b001;
                    PH_SIDE: yellow = 3'b010;
                    PH_LEFT: yellow = 3'b100;
                    default: all_red = 1'b1;
                endcase
            end
            default: all_red = 1'b1;
        endcase
    end

    assign cur_phase = r_phase;
    assign req_pend  = r_pend;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler at TICK_DIV=4: directed scenarios plus
// randomized requests compared against a tick-level service model.
module tb_intersection_phase_scheduler;

    localparam int TD    = 4;
    localparam int MIN_G = 6;
    localparam int MAX_G = 12;
    localparam int YEL   = 2;
    localparam int AR    = 1;
    localparam int WLK   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_in = 3'b000;
    logic [3:0] grant;
    logic [2:0] yellow;
    logic       all_red;
    logic [1:0] cur_phase;
    logic [2:0] req_pend;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // model: what is lit (0 green, 1 yellow, 2 all-red), for whom, how many
    // ticks it has already been lit, pending demand and rotation start
    int       m_kind, m_ph, m_served, m_rr, m_pre, m_ticks;
    bit [2:0] m_pend;

    intersection_phase_scheduler #(
        .TICK_DIV(TD), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
        .YELLOW_T(YEL), .ALLRED_T(AR), .WALK_T(WLK)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .grant(grant), .yellow(yellow),
        .all_red(all_red), .cur_phase(cur_phase), .req_pend(req_pend)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot({grant, yellow, all_red})) begin
                bad++;
                $display("FAIL onehot t=%0t got grant=%b yellow=%b all_red=%b need exactly one", $time, grant, yellow, all_red);
            end
        end
    end

    function automatic int dur_of(input int kind, input int ph);
        if (kind == 1) return YEL;
        if (kind == 2) return AR;
        if (ph == 3)   return WLK;
        return MIN_G;
    endfunction

    task automatic model_update(input bit r, input bit [2:0] q);
        int  nk, nph, lit;
        bit  tick;
        bit [2:0] np;
        if (r) begin
            m_kind = 0; m_ph = 0; m_served = 0; m_pend = 3'b000;
            m_rr = 1; m_pre = 0; m_ticks = 0;
            return;
        end
        tick  = (m_pre == TD - 1);
        m_pre = (m_pre + 1) % TD;
        nk = m_kind; nph = m_ph;
        if (tick) begin
            m_ticks++;
            lit = m_served + 1;
            if (m_kind == 0 && m_ph == 0) begin
                if (lit >= MIN_G && m_pend != 3'b000) nk = 1;
            end else if (m_kind == 0 && (m_ph == 1 || m_ph == 2)) begin
                if (lit >= MAX_G || (lit >= MIN_G && !q[m_ph-1])) nk = 1;
            end else if (m_kind == 0) begin
                if (lit >= dur_of(0, 3)) nk = 2;
            end else if (m_kind == 1) begin
                if (lit >= dur_of(1, m_ph)) nk = 2;
            end else if (lit >= dur_of(2, m_ph)) begin
                nk = 0;
                if (m_ph != 0) nph = 0;
                else begin
                    nph = 0;
                    for (int k = 0; k < 3; k++) begin
                        int c;
                        c = ((m_rr - 1 + k) % 3) + 1;
                        if (nph == 0 && m_pend[c-1]) nph = c;
                    end
                    if (nph != 0) m_rr = (nph % 3) + 1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            np[i] = m_pend[i] | (q[i] && !(m_kind == 0 && m_ph == i + 1));
            if (nk == 0 && m_kind != 0 && nph == i + 1) np[i] = 1'b0;
        end
        if (tick) m_served = (nk != m_kind) ? 0 : m_served + 1;
        m_kind = nk; m_ph = nph; m_pend = np;
    endtask

    function automatic logic [12:0] exp_vec();
        logic [3:0] g;
        logic [2:0] y;
        g = (m_kind == 0) ? 4'(1 << m_ph) : 4'b0000;
        y = (m_kind == 1) ? 3'(1 << m_ph) : 3'b000;
        return {g, y, (m_kind == 2), 2'(m_ph), m_pend};
    endfunction

    task automatic step(input logic r, input logic [2:0] q);
        rst = r; req_in = q;
        @(posedge clk);
        model_update(r, q);
        #1;
    endtask

    task automatic test_reset();
        int lit_other;
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        mon_en = 1'b1;
        total++;
        if ({grant, yellow, all_red, cur_phase, req_pend} !== 13'b0001_000_0_00_000) begin
            bad++;
            $display("FAIL reset_state got %b need %b", {grant, yellow, all_red, cur_phase, req_pend}, 13'b0001_000_0_00_000);
        end
        lit_other = 0;
        for (int c = 0; c < 100 * TD; c++) begin
            step(1'b0, 3'b000);
            if (grant !== 4'b0001 || yellow !== 3'b000 || all_red !== 1'b0) lit_other++;
        end
        total++;
        if (lit_other !== 0) begin
            bad++;
            $display("FAIL rest_main got %0d non-MAIN cycles need 0", lit_other);
        end
    endtask

    task automatic test_side_pulse();
        int side_c, y0_c, y1_c, ar_c, first_y, n;
        logic [2:0] pend_at_side;
        step(1'b1, 3'b000);
        n = 0;
        while (m_ticks < 2 && n < 50) begin step(1'b0, 3'b000); n++; end
        step(1'b0, 3'b001);
        total++;
        if (req_pend !== 3'b001) begin
            bad++;
            $display("FAIL side_latch got req_pend=%b need 001", req_pend);
        end
        side_c = 0; y0_c = 0; y1_c = 0; ar_c = 0; first_y = -1; pend_at_side = 3'b111;
        for (int c = 0; c < 50 * TD; c++) begin
            step(1'b0, 3'b000);
            total++;
            if ({grant, yellow, all_red, cur_phase, req_pend} !== exp_vec()) begin
                bad++;
                $display("FAIL side_model c=%0d got %b need %b", c, {grant, yellow, all_red, cur_phase, req_pend}, exp_vec());
            end
            if (grant == 4'b0010) begin
                if (side_c == 0) pend_at_side = req_pend;
                side_c++;
            end
            if (yellow == 3'b001) begin
                if (first_y < 0) first_y = m_ticks;
                y0_c++;
            end
            if (yellow == 3'b010) y1_c++;
            if (all_red) ar_c++;
        end
        total++;
        if (first_y !== 6) begin bad++; $display("FAIL main_end_tick got %0d need 6", first_y); end
        total++;
        if (y0_c !== YEL * TD) begin bad++; $display("FAIL main_yellow got %0d need %0d", y0_c, YEL * TD); end
        total++;
        if (side_c !== MIN_G * TD) begin bad++; $display("FAIL side_green got %0d need %0d", side_c, MIN_G * TD); end
        total++;
        if (pend_at_side !== 3'b000) begin bad++; $display("FAIL side_clear got %b need 000", pend_at_side); end
        total++;
        if (y1_c !== YEL * TD || ar_c !== 2 * AR * TD) begin
            bad++;
            $display("FAIL side_clearance got y=%0d ar=%0d need %0d %0d", y1_c, ar_c, YEL * TD, 2 * AR * TD);
        end
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL side_return got %b need 0001", grant); end
    endtask

    task automatic test_left_hold();
        int left_c, n, ext_latch;
        step(1'b1, 3'b000);
        left_c = 0; n = 0; ext_latch = 0;
        while (yellow !== 3'b100 && n < 400) begin
            step(1'b0, 3'b010);
            n++;
            if (grant == 4'b0100) begin
                left_c++;
                if (req_pend !== 3'b000) ext_latch++;
            end
        end
        total++;
        if (n >= 400) begin bad++; $display("FAIL left_timeout got no yellow[2] need one within 400"); end
        total++;
        if (left_c !== MAX_G * TD) begin bad++; $display("FAIL left_max got %0d need %0d", left_c, MAX_G * TD); end
        total++;
        if (ext_latch !== 0) begin bad++; $display("FAIL left_ext_latch got %0d need 0", ext_latch); end
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 3'b000);
            total++;
            if ({grant, yellow, all_red, cur_phase, req_pend} !== exp_vec()) begin
                bad++;
                $display("FAIL left_model c=%0d got %b need %b", c, {grant, yellow, all_red, cur_phase, req_pend}, exp_vec());
            end
        end
    endtask

    task automatic test_all_three();
        logic [3:0] seq[$];
        logic [3:0] want[7];
        logic [3:0] prev;
        int walk_c, after_walk_ar, n;
        want = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001};
        step(1'b1, 3'b000);
        for (int c = 0; c < 3; c++) step(1'b0, 3'b000);
        step(1'b0, 3'b111);
        seq.push_back(grant);
        prev = grant; walk_c = 0; after_walk_ar = -1; n = 0;
        while (seq.size() < 7 && n < 600) begin
            step(1'b0, 3'b000);
            n++;
            if (prev == 4'b1000 && grant != 4'b1000) after_walk_ar = all_red;
            if (grant == 4'b1000) walk_c++;
            if (grant != 4'b0000 && grant != seq[seq.size()-1]) seq.push_back(grant);
            if (grant != 4'b0000 || yellow != 3'b000 || all_red) prev = grant;
        end
        total++;
        if (seq.size() !== 7) begin
            bad++;
            $display("FAIL order_len got %0d need 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                total++;
                if (seq[i] !== want[i]) begin
                    bad++;
                    $display("FAIL order_%0d got %b need %b", i, seq[i], want[i]);
                end
            end
        end
        total++;
        if (walk_c !== WLK * TD) begin bad++; $display("FAIL walk_len got %0d need %0d", walk_c, WLK * TD); end
        total++;
        if (after_walk_ar !== 1) begin bad++; $display("FAIL walk_no_yellow got %0d need 1", after_walk_ar); end
    endtask

    task automatic test_reset_mid();
        int n;
        step(1'b1, 3'b000);
        step(1'b0, 3'b011);
        n = 0;
        while (yellow !== 3'b010 && n < 400) begin step(1'b0, 3'b000); n++; end
        total++;
        if (n >= 400 || req_pend !== 3'b010) begin
            bad++;
            $display("FAIL mid_setup got yellow=%b pend=%b need 010 010", yellow, req_pend);
        end
        step(1'b1, 3'b000);
        total++;
        if ({grant, yellow, all_red, cur_phase, req_pend} !== 13'b0001_000_0_00_000) begin
            bad++;
            $display("FAIL mid_reset got %b need %b", {grant, yellow, all_red, cur_phase, req_pend}, 13'b0001_000_0_00_000);
        end
        step(1'b0, 3'b100);
        for (int c = 0; c < 200; c++) begin
            step(1'b0, 3'b000);
            total++;
            if ({grant, yellow, all_red, cur_phase, req_pend} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_model c=%0d got %b need %b", c, {grant, yellow, all_red, cur_phase, req_pend}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] q;
        int hold;
        logic r;
        q = 3'b000; hold = 0;
        step(1'b1, 3'b000);
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                q = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) q = 3'b000;
                hold = $urandom_range(1, 60);
            end
            hold--;
            r = ($urandom_range(0, 499) == 0);
            step(r, q);
            total++;
            if ({grant, yellow, all_red, cur_phase, req_pend} !== exp_vec()) begin
                bad++;
                $display("FAIL rand_model c=%0d req=%b got %b need %b", c, q, {grant, yellow, all_red, cur_phase, req_pend}, exp_vec());
            end
        end
    endtask

    initial begin
        m_kind = 0; m_ph = 0; m_served = 0; m_pend = 3'b000; m_rr = 1; m_pre = 0; m_ticks = 0;
        test_reset();
        test_side_pulse();
        test_left_hold();
        test_all_three();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
